path_planner_bfs: RTL and testbench

Parametrised shortest-path engine for the PathPlanning subsystem. It replaces the fixed 5-bit / 20-slot path decoder with a runtime-loadable directed adjacency matrix and a breadth-first search. A start/busy/done handshake and found/length status report the result. The block emits a packed node path from st_node to end_node for the downstream motion sequencer.

---
 rtl/path_planner_bfs_pkg.sv | 8 +
 rtl/path_planner_bfs_queue.sv | 33 +++
 rtl/path_planner_bfs.sv | 130 +++++++++++++
 tb/tb_path_planner_bfs.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/path_planner_bfs_pkg.sv
// path_pkg: shared FSM states, sentinel value and slot-offset helper for the BFS planner
package path_pkg;
  typedef enum logic [2:0] {IDLE, INIT, DEQ, EXPAND, TRACE, DONE} state_t;
  localparam logic [31:0] SENTINEL = '1;
  function automatic int slot_off(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/path_planner_bfs_queue.sv
// bfs_queue: show-ahead FIFO of node indices; clear rewinds both pointers
module bfs_queue #(
  parameter int W = 5,
  parameter int DEPTH = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr, wr_base;
  assign wr_base = clear ? '0 : wr;
  assign empty = rd == wr;
  assign dout = mem[rd];
  // storage: a push in the clearing cycle lands in slot 0
  always_ff @(posedge clk)
    if (push) mem[wr_base] <= din;
  // pointers: each node is pushed at most once per search, so no wrap is needed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
    end else begin
      wr <= wr_base + PW'(push);
      rd <= clear ? '0 : rd + PW'(pop);
    end
endmodule

// File: rtl/path_planner_bfs.sv
// path_planner_bfs: loadable adjacency matrix with backward BFS producing a packed node path
module path_planner_bfs
  import path_pkg::*;
#(
  parameter int NODE_W = 5,
  parameter int MAX_NODES = 26,
  parameter int MAX_PATH = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       adj_we,
  input  logic [NODE_W-1:0]          adj_row,
  input  logic [MAX_NODES-1:0]       adj_data,
  input  logic                       start,
  input  logic [NODE_W-1:0]          st_node,
  input  logic [NODE_W-1:0]          end_node,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic                       ovf,
  output logic [NODE_W:0]            path_len,
  output logic [MAX_PATH*NODE_W-1:0] path
);
  localparam logic [NODE_W-1:0] SENT = NODE_W'(SENTINEL);
  localparam logic [NODE_W-1:0] LAST = NODE_W'(MAX_NODES - 1);
  localparam logic [NODE_W:0] PLAST = (NODE_W + 1)'(MAX_PATH - 1);
  state_t state, nxt;
  logic [MAX_NODES-1:0] adj [MAX_NODES];
  logic [MAX_NODES-1:0] visited;
  logic [NODE_W-1:0] parent [MAX_NODES];
  logic [NODE_W-1:0] st, en, u, v, cur, q_din, q_dout;
  logic q_push, q_pop, q_clr, q_empty, bad, cand;
  assign bad = int'(st) >= MAX_NODES || int'(en) >= MAX_NODES;
  assign cand = adj[v][u] && !visited[v];
  assign q_din = state == INIT ? en : v;
  bfs_queue #(.W(NODE_W), .DEPTH(MAX_NODES)) queue (
    .clk(clk), .rst_n(rst_n), .push(q_push), .pop(q_pop), .clear(q_clr),
    .din(q_din), .dout(q_dout), .empty(q_empty)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state, queue strobes and handshake outputs
  always_comb begin
    nxt = state;
    q_push = 1'b0;
    q_pop = 1'b0;
    q_clr = 1'b0;
    case (state)
      IDLE: nxt = start ? INIT : IDLE;
      INIT: begin
        q_clr = 1'b1;
        q_push = !bad && st != en;
        nxt = (bad || st == en) ? DONE : DEQ;
      end
      DEQ: begin
        q_pop = !q_empty;
        nxt = q_empty ? DONE : EXPAND;
      end
      EXPAND: begin
        q_push = cand;
        nxt = (cand && v == st) ? TRACE : v == LAST ? DEQ : EXPAND;
      end
      TRACE: nxt = (cur == en || path_len == PLAST) ? DONE : TRACE;
      default: nxt = IDLE;
    endcase
    busy = state != IDLE && state != DONE;
    done = state == DONE;
  end
  // search bookkeeping: cleared per search, so no reset is needed
  always_ff @(posedge clk)
    if (state == INIT) begin
      visited <= '0;
      if (!bad) visited[en] <= 1'b1;
      for (int i = 0; i < MAX_NODES; i++) parent[i] <= SENT;
    end else if (state == EXPAND && cand) begin
      visited[v] <= 1'b1;
      parent[v] <= u;
    end
  // adjacency, captured nodes, scan indices and result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < MAX_NODES; i++) adj[i] <= '0;
      st <= '0;
      en <= '0;
      u <= '0;
      v <= '0;
      cur <= '0;
      found <= 1'b0;
      ovf <= 1'b0;
      path_len <= '0;
      path <= {MAX_PATH{SENT}};
    end else begin
      case (state)
        IDLE: begin
          if (adj_we && int'(adj_row) < MAX_NODES) adj[adj_row] <= adj_data;
          if (start) begin
            st <= st_node;
            en <= end_node;
          end
        end
        INIT: begin
          path <= {MAX_PATH{SENT}};
          path_len <= '0;
          found <= 1'b0;
          ovf <= 1'b0;
          cur <= st;
          if (!bad && st == en) begin
            path[NODE_W-1:0] <= st;
            path_len <= (NODE_W + 1)'(1);
            found <= 1'b1;
          end
        end
        DEQ: begin
          u <= q_dout;
          v <= '0;
        end
        EXPAND: v <= v + 1'b1;
        TRACE: begin
          path[slot_off(int'(path_len), NODE_W) +: NODE_W] <= cur;
          path_len <= path_len + 1'b1;
          cur <= parent[cur];
          if (cur == en) found <= 1'b1;
          else if (path_len == PLAST) ovf <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_path_planner_bfs.sv
// tb_path_planner_bfs: directed searches with a scoreboard checked on every done pulse
module tb_path_planner_bfs;
  logic clk, rst_n, adj_we, start, busy, done, found, ovf;
  logic [4:0] adj_row, st_node, end_node;
  logic [25:0] adj_data;
  logic [5:0] path_len;
  logic [99:0] path;
  typedef struct packed {
    logic f;
    logic o;
    logic [5:0] len;
    logic [99:0] p;
  } exp_t;
  exp_t sb[$];
  exp_t m_exp;
  int compared = 0;
  int mismatched = 0;
  logic [99:0] p_chain, p_short, p_tmp;

  path_planner_bfs dut (
    .clk(clk), .rst_n(rst_n), .adj_we(adj_we), .adj_row(adj_row), .adj_data(adj_data),
    .start(start), .st_node(st_node), .end_node(end_node), .busy(busy), .done(done),
    .found(found), .ovf(ovf), .path_len(path_len), .path(path)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [99:0] put(input logic [99:0] p, input int k, input int val);
    p[k*5 +: 5] = 5'(val);
    return p;
  endfunction

  // monitor: every done pulse is matched against the oldest expected result
  always @(negedge clk)
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 expected no pending search");
      end else begin
        m_exp = sb.pop_front();
        chk("found", found, m_exp.f);
        chk("ovf", ovf, m_exp.o);
        chk("path_len", path_len, m_exp.len);
        chk("path", path, m_exp.p);
      end
    end

  task automatic wrow(input int r, input logic [25:0] d);
    adj_we = 1;
    adj_row = 5'(r);
    adj_data = d;
    @(posedge clk) #1 adj_we = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2 rst_n = 1;
    @(posedge clk) #1;
  endtask

  // issue one search; poke injects a start and a row-3 write while busy
  task automatic run(input int s, input int e, input logic f, input logic o, input int len,
                     input logic [99:0] p, input int exp_lat, input bit poke);
    int lat;
    sb.push_back('{f, o, 6'(len), p});
    st_node = 5'(s);
    end_node = 5'(e);
    start = 1;
    @(negedge clk);
    lat = 1;
    @(posedge clk) #1 start = 0;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 5) begin
        st_node = 5;
        end_node = 5;
        adj_row = 3;
        adj_data = '0;
      end
      if (poke) begin
        start = (lat == 5);
        adj_we = (lat == 5);
      end
    end
    start = 0;
    adj_we = 0;
    chk("done_seen", done, 1);
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    @(posedge clk) #1;
    chk("busy_released", busy, 0);
  endtask

  initial begin
    int n;
    rst_n = 0;
    adj_we = 0;
    adj_row = 0;
    adj_data = 0;
    start = 0;
    st_node = 0;
    end_node = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_path_len", path_len, 0);
    chk("rst_path", path, {100{1'b1}});
    @(posedge clk) #1 rst_n = 1;
    @(posedge clk) #1;

    p_chain = put(put(put(put('1, 0, 3), 1, 7), 2, 12), 3, 25);
    p_short = put(put('1, 0, 3), 1, 25);
    wrow(3, 26'(1) << 7);
    wrow(7, 26'(1) << 12);
    wrow(12, 26'(1) << 25);
    run(3, 25, 1, 0, 4, p_chain, 0, 0);
    wrow(3, (26'(1) << 7) | (26'(1) << 25));
    run(3, 25, 1, 0, 2, p_short, 0, 0);
    run(5, 5, 1, 0, 1, put('1, 0, 5), 3, 0);
    run(27, 25, 0, 0, 0, '1, 3, 0);

    do_reset();
    wrow(3, 26'(1) << 7);
    run(3, 25, 0, 0, 0, '1, 0, 0);

    do_reset();
    for (int i = 0; i < 21; i++) wrow(i, 26'(1) << (i + 1));
    p_tmp = '1;
    for (int k = 0; k < 20; k++) p_tmp = put(p_tmp, k, k);
    run(0, 21, 0, 1, 20, p_tmp, 0, 0);

    do_reset();
    wrow(3, 26'(1) << 7);
    wrow(7, 26'(1) << 12);
    wrow(12, 26'(1) << 25);
    run(3, 25, 1, 0, 4, p_chain, 0, 1);
    run(3, 25, 1, 0, 4, p_chain, 0, 0);

    st_node = 3;
    end_node = 25;
    start = 1;
    @(posedge clk) #1 start = 0;
    repeat (4) @(posedge clk);
    #2 chk("busy_mid", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_path", path, {100{1'b1}});
    chk("mid_rst_path_len", path_len, 0);
    chk("mid_rst_found", found, 0);
    @(posedge clk) #1 rst_n = 1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("no_done_after_rst", n, 0);
    @(posedge clk) #1;
    run(3, 25, 0, 0, 0, '1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
